// File: rtl/fma_operand_unpacker.sv
// FMA front end: unpacks three IEEE-754 single-precision operands into
// sign/exponent/mantissa, class flags and leading-zero counts over a 2-stage pipeline.
module fma_operand_unpacker #(
  parameter int                PARM_RM            = 3,
  parameter logic [PARM_RM-1:0] PARM_RM_RMM       = 3'b100,
  parameter int                PARM_EXP           = 8,
  parameter int                PARM_MANT          = 23,
  parameter int                PARM_LEADONE_WIDTH = 5
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          In_valid_i,
  output logic                          In_ready_o,
  input  logic [PARM_EXP+PARM_MANT:0]   A_i,
  input  logic [PARM_EXP+PARM_MANT:0]   B_i,
  input  logic [PARM_EXP+PARM_MANT:0]   C_i,
  input  logic [PARM_RM-1:0]            Rounding_mode_i,
  output logic                          Out_valid_o,
  input  logic                          Out_ready_i,
  output logic                          A_Sign_o,
  output logic [PARM_EXP-1:0]           A_Exp_raw_o,
  output logic [PARM_MANT:0]            A_Mant_o,
  output logic                          A_DeN_o,
  output logic                          A_Inf_o,
  output logic                          A_Zero_o,
  output logic                          A_NaN_o,
  output logic                          A_SNaN_o,
  output logic [PARM_LEADONE_WIDTH-1:0] A_Lz_o,
  output logic                          B_Sign_o,
  output logic [PARM_EXP-1:0]           B_Exp_raw_o,
  output logic [PARM_MANT:0]            B_Mant_o,
  output logic                          B_DeN_o,
  output logic                          B_Inf_o,
  output logic                          B_Zero_o,
  output logic                          B_NaN_o,
  output logic                          B_SNaN_o,
  output logic [PARM_LEADONE_WIDTH-1:0] B_Lz_o,
  output logic                          C_Sign_o,
  output logic [PARM_EXP-1:0]           C_Exp_raw_o,
  output logic [PARM_MANT:0]            C_Mant_o,
  output logic                          C_DeN_o,
  output logic                          C_Inf_o,
  output logic                          C_Zero_o,
  output logic                          C_NaN_o,
  output logic                          C_SNaN_o,
  output logic [PARM_LEADONE_WIDTH-1:0] C_Lz_o,
  output logic                          Sub_Sign_o,
  output logic                          Invalid_early_o,
  output logic [PARM_RM-1:0]            Rounding_mode_o,
  output logic                          Rm_illegal_o
);

  localparam int W  = PARM_EXP + PARM_MANT + 1;
  localparam int LW = PARM_LEADONE_WIDTH;

  typedef struct packed {
    logic                 sign;
    logic [PARM_EXP-1:0]  exp;
    logic [PARM_MANT:0]   mant;
    logic                 den;
    logic                 inf;
    logic                 zero;
    logic                 nan;
    logic                 snan;
    logic [LW-1:0]        lz;
  } op_t;

  function automatic op_t unpack(input logic [W-1:0] x);
    op_t                  o;
    logic [PARM_MANT-1:0] f;
    logic                 e_zero;
    logic                 e_ones;
    f       = x[PARM_MANT-1:0];
    o.sign  = x[W-1];
    o.exp   = x[W-2:PARM_MANT];
    e_zero  = (o.exp == '0);
    e_ones  = &o.exp;
    o.mant  = {~e_zero, f};
    o.zero  = e_zero & (f == '0);
    o.den   = e_zero & (f != '0);
    o.inf   = e_ones & (f == '0);
    o.nan   = e_ones & (f != '0);
    o.snan  = o.nan & ~f[PARM_MANT-1];
    // Ascending scan so the highest set bit wins; all-zero saturates.
    o.lz    = LW'(PARM_MANT + 1);
    for (int i = 0; i <= PARM_MANT; i++) begin
      if (o.mant[i]) o.lz = LW'(PARM_MANT - i);
    end
    return o;
  endfunction

  logic               s1_valid_q, s1_valid_d;
  logic [W-1:0]       s1_a_q, s1_b_q, s1_c_q;
  logic [PARM_RM-1:0] s1_rm_q;

  logic               s2_valid_q, s2_valid_d;
  op_t                s2_a_q, s2_b_q, s2_c_q;
  logic               s2_sub_q, s2_inv_q, s2_ill_q;
  logic [PARM_RM-1:0] s2_rm_q;

  logic s2_adv, in_ready, s1_load, s2_load;
  op_t  op_a_d, op_b_d, op_c_d;
  logic sub_d, inv_d, ill_d;

  always_comb begin
    s2_adv     = ~s2_valid_q | Out_ready_i;
    in_ready   = ~s1_valid_q | s2_adv;
    s1_load    = in_ready & In_valid_i;
    s1_valid_d = in_ready ? In_valid_i : s1_valid_q;
    s2_valid_d = s2_adv ? s1_valid_q : s2_valid_q;
    s2_load    = s2_adv & s1_valid_q;

    op_a_d = unpack(s1_a_q);
    op_b_d = unpack(s1_b_q);
    op_c_d = unpack(s1_c_q);
    sub_d  = op_a_d.sign ^ op_b_d.sign ^ op_c_d.sign;
    // 0*Inf in the product, or Inf - Inf between addend and product.
    inv_d  = op_a_d.snan | op_b_d.snan | op_c_d.snan
           | (op_b_d.zero & op_c_d.inf) | (op_c_d.zero & op_b_d.inf)
           | (sub_d & op_a_d.inf & (op_b_d.inf | op_c_d.inf));
    ill_d  = (s1_rm_q > PARM_RM_RMM);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_c_q     <= '0;
      s1_rm_q    <= '0;
      s2_valid_q <= 1'b0;
      s2_a_q     <= '0;
      s2_b_q     <= '0;
      s2_c_q     <= '0;
      s2_sub_q   <= 1'b0;
      s2_inv_q   <= 1'b0;
      s2_ill_q   <= 1'b0;
      s2_rm_q    <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      if (s1_load) begin
        s1_a_q  <= A_i;
        s1_b_q  <= B_i;
        s1_c_q  <= C_i;
        s1_rm_q <= Rounding_mode_i;
      end
      if (s2_load) begin
        s2_a_q   <= op_a_d;
        s2_b_q   <= op_b_d;
        s2_c_q   <= op_c_d;
        s2_sub_q <= sub_d;
        s2_inv_q <= inv_d;
        s2_ill_q <= ill_d;
        s2_rm_q  <= s1_rm_q;
      end
    end
  end

  assign In_ready_o      = in_ready;
  assign Out_valid_o     = s2_valid_q;
  assign Sub_Sign_o      = s2_sub_q;
  assign Invalid_early_o = s2_inv_q;
  assign Rounding_mode_o = s2_rm_q;
  assign Rm_illegal_o    = s2_ill_q;

  assign {A_Sign_o, A_Exp_raw_o, A_Mant_o, A_DeN_o, A_Inf_o, A_Zero_o, A_NaN_o, A_SNaN_o, A_Lz_o} = s2_a_q;
  assign {B_Sign_o, B_Exp_raw_o, B_Mant_o, B_DeN_o, B_Inf_o, B_Zero_o, B_NaN_o, B_SNaN_o, B_Lz_o} = s2_b_q;
  assign {C_Sign_o, C_Exp_raw_o, C_Mant_o, C_DeN_o, C_Inf_o, C_Zero_o, C_NaN_o, C_SNaN_o, C_Lz_o} = s2_c_q;

endmodule

// File: tb/tb_fma_operand_unpacker.sv
// Bench for fma_operand_unpacker: directed test-plan vectors plus random
// operand/handshake traffic checked against an arithmetic reference model.
module tb_fma_operand_unpacker;

  logic        clk = 1'b0;
  logic        rst;
  logic        In_valid_i, In_ready_o, Out_valid_o, Out_ready_i;
  logic [31:0] A_i, B_i, C_i;
  logic [2:0]  Rounding_mode_i, Rounding_mode_o;
  logic        A_Sign_o, B_Sign_o, C_Sign_o;
  logic [7:0]  A_Exp_raw_o, B_Exp_raw_o, C_Exp_raw_o;
  logic [23:0] A_Mant_o, B_Mant_o, C_Mant_o;
  logic        A_DeN_o, A_Inf_o, A_Zero_o, A_NaN_o, A_SNaN_o;
  logic        B_DeN_o, B_Inf_o, B_Zero_o, B_NaN_o, B_SNaN_o;
  logic        C_DeN_o, C_Inf_o, C_Zero_o, C_NaN_o, C_SNaN_o;
  logic [4:0]  A_Lz_o, B_Lz_o, C_Lz_o;
  logic        Sub_Sign_o, Invalid_early_o, Rm_illegal_o;

  fma_operand_unpacker dut (
    .clk(clk), .rst(rst),
    .In_valid_i(In_valid_i), .In_ready_o(In_ready_o),
    .A_i(A_i), .B_i(B_i), .C_i(C_i), .Rounding_mode_i(Rounding_mode_i),
    .Out_valid_o(Out_valid_o), .Out_ready_i(Out_ready_i),
    .A_Sign_o(A_Sign_o), .A_Exp_raw_o(A_Exp_raw_o), .A_Mant_o(A_Mant_o),
    .A_DeN_o(A_DeN_o), .A_Inf_o(A_Inf_o), .A_Zero_o(A_Zero_o), .A_NaN_o(A_NaN_o),
    .A_SNaN_o(A_SNaN_o), .A_Lz_o(A_Lz_o),
    .B_Sign_o(B_Sign_o), .B_Exp_raw_o(B_Exp_raw_o), .B_Mant_o(B_Mant_o),
    .B_DeN_o(B_DeN_o), .B_Inf_o(B_Inf_o), .B_Zero_o(B_Zero_o), .B_NaN_o(B_NaN_o),
    .B_SNaN_o(B_SNaN_o), .B_Lz_o(B_Lz_o),
    .C_Sign_o(C_Sign_o), .C_Exp_raw_o(C_Exp_raw_o), .C_Mant_o(C_Mant_o),
    .C_DeN_o(C_DeN_o), .C_Inf_o(C_Inf_o), .C_Zero_o(C_Zero_o), .C_NaN_o(C_NaN_o),
    .C_SNaN_o(C_SNaN_o), .C_Lz_o(C_Lz_o),
    .Sub_Sign_o(Sub_Sign_o), .Invalid_early_o(Invalid_early_o),
    .Rounding_mode_o(Rounding_mode_o), .Rm_illegal_o(Rm_illegal_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a, b, c;
    logic [2:0]  rm;
  } set_t;

  set_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  logic last_acc, last_ovalid;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_inf(input logic [31:0] x);
    return x[30:0] == 31'h7F80_0000;
  endfunction
  function automatic bit is_zero(input logic [31:0] x);
    return x[30:0] == 31'h0;
  endfunction
  function automatic bit is_snan(input logic [31:0] x);
    return x[30:23] == 8'hFF && x[22] == 1'b0 && x[21:0] != 0;
  endfunction

  // {sign, exp, mant, den, inf, zero, nan, snan, lz}
  function automatic logic [42:0] op_model(input logic [31:0] x);
    int e, f, m, v, lz;
    bit zero, den, inf, nan, snan;
    e    = int'(x[30:23]);
    f    = int'(x[22:0]);
    zero = (e == 0) && (f == 0);
    den  = (e == 0) && (f != 0);
    inf  = (e == 255) && (f == 0);
    nan  = (e == 255) && (f != 0);
    snan = nan && (f < (1 << 22));
    m    = f + ((e != 0) ? (1 << 23) : 0);
    if (m == 0) lz = 24;
    else begin
      lz = 0;
      v  = m;
      while (v < (1 << 23)) begin
        v  = v * 2;
        lz = lz + 1;
      end
    end
    return {x[31], 8'(e), 24'(m), den, inf, zero, nan, snan, 5'(lz)};
  endfunction

  // {sub, invalid, rm, rm_illegal}
  function automatic logic [5:0] misc_model(input set_t s);
    bit sub, inv;
    sub = s.a[31] ^ s.b[31] ^ s.c[31];
    inv = is_snan(s.a) || is_snan(s.b) || is_snan(s.c)
       || (is_zero(s.b) && is_inf(s.c)) || (is_zero(s.c) && is_inf(s.b))
       || (sub && is_inf(s.a) && (is_inf(s.b) || is_inf(s.c)));
    return {sub, inv, s.rm, (int'(s.rm) > 4)};
  endfunction

  task automatic cmp_set(input set_t s, input string ph);
    chk({ph, "_A"}, 64'({A_Sign_o, A_Exp_raw_o, A_Mant_o, A_DeN_o, A_Inf_o, A_Zero_o,
                          A_NaN_o, A_SNaN_o, A_Lz_o}), 64'(op_model(s.a)));
    chk({ph, "_B"}, 64'({B_Sign_o, B_Exp_raw_o, B_Mant_o, B_DeN_o, B_Inf_o, B_Zero_o,
                          B_NaN_o, B_SNaN_o, B_Lz_o}), 64'(op_model(s.b)));
    chk({ph, "_C"}, 64'({C_Sign_o, C_Exp_raw_o, C_Mant_o, C_DeN_o, C_Inf_o, C_Zero_o,
                          C_NaN_o, C_SNaN_o, C_Lz_o}), 64'(op_model(s.c)));
    chk({ph, "_misc"}, 64'({Sub_Sign_o, Invalid_early_o, Rounding_mode_o, Rm_illegal_o}),
        64'(misc_model(s)));
  endtask

  // One clock: drive at negedge, sample #1 later, transfers land on the next posedge.
  task automatic cycle(input logic iv, input set_t s, input logic ordy);
    @(negedge clk);
    In_valid_i      = iv;
    A_i             = s.a;
    B_i             = s.b;
    C_i             = s.c;
    Rounding_mode_i = s.rm;
    Out_ready_i     = ordy;
    #1;
    last_ovalid = Out_valid_o;
    last_acc    = In_valid_i && In_ready_o;
    if (Out_valid_o) begin
      if (sb.size() == 0) chk("spurious_out", 64'(Out_valid_o), 64'(0));
      else begin
        cmp_set(sb[0], Out_ready_i ? "xfer" : "hold");
        if (Out_ready_i) void'(sb.pop_front());
      end
    end
    if (last_acc) sb.push_back(s);
  endtask

  function automatic logic [31:0] rnd_op();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 6))
      0: r[30:0] = 31'h0;
      1: r[30:23] = 8'h00;
      2: r[30:0] = 31'h7F80_0000;
      3: r[30:23] = 8'hFF;
      4: begin r[30:23] = 8'hFF; r[22] = 1'b0; end
      default: ;
    endcase
    return r;
  endfunction

  function automatic set_t rnd_set();
    set_t s;
    s.a  = rnd_op();
    s.b  = rnd_op();
    s.c  = rnd_op();
    s.rm = 3'($urandom_range(0, 7));
    return s;
  endfunction

  function automatic set_t mk(input logic [31:0] a, b, c, input logic [2:0] rm);
    set_t s;
    s.a = a; s.b = b; s.c = c; s.rm = rm;
    return s;
  endfunction

  // Lone set into an empty pipe; returns with its outputs visible.
  task automatic send_alone(input set_t s, input string tag);
    set_t z;
    z = mk(0, 0, 0, 0);
    cycle(1'b1, s, 1'b1);
    chk({tag, "_accept"}, 64'(last_acc), 64'(1));
    cycle(1'b0, z, 1'b1);
    chk({tag, "_lat_n1"}, 64'(last_ovalid), 64'(0));
    cycle(1'b0, z, 1'b1);
    chk({tag, "_lat_n2"}, 64'(last_ovalid), 64'(1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time %0t exceeded limit", $time);
    $fatal(1);
  end

  initial begin
    set_t st[5];
    set_t z;
    int   idx;
    z = mk(0, 0, 0, 0);
    rst = 1'b1;
    In_valid_i = 1'b0; Out_ready_i = 1'b1;
    A_i = '0; B_i = '0; C_i = '0; Rounding_mode_i = '0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_out_valid", 64'(Out_valid_o), 64'(0));
    chk("rst_in_ready", 64'(In_ready_o), 64'(1));
    chk("rst_data", 64'({A_Exp_raw_o, A_Mant_o, Invalid_early_o, Rounding_mode_o}), 64'(0));
    rst = 1'b0;

    send_alone(mk(32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 3'd0), "one");
    chk("one_exp", 64'(A_Exp_raw_o), 64'h7F);
    chk("one_mant", 64'(A_Mant_o), 64'h80_0000);
    chk("one_lz", 64'(A_Lz_o), 64'(0));
    chk("one_flags", 64'({A_Sign_o, A_DeN_o, A_Inf_o, A_Zero_o, A_NaN_o, A_SNaN_o}), 64'(0));

    send_alone(mk(32'h0000_0001, 32'h3F80_0000, 32'h3F80_0000, 3'd1), "den");
    chk("den_flag", 64'(A_DeN_o), 64'(1));
    chk("den_mant", 64'(A_Mant_o), 64'h1);
    chk("den_lz", 64'(A_Lz_o), 64'd23);

    send_alone(mk(32'h8000_0000, 32'h3F80_0000, 32'h3F80_0000, 3'd2), "zero");
    chk("zero_flags", 64'({A_Zero_o, A_Sign_o}), 64'b11);
    chk("zero_lz", 64'(A_Lz_o), 64'd24);

    send_alone(mk(32'h3F80_0000, 32'h7F80_0001, 32'h3F80_0000, 3'd0), "snan");
    chk("snan_flags", 64'({B_NaN_o, B_SNaN_o, Invalid_early_o}), 64'b111);

    send_alone(mk(32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000, 3'd0), "zinf");
    chk("zinf_invalid", 64'(Invalid_early_o), 64'(1));

    send_alone(mk(32'h3F80_0000, 32'hC000_0000, 32'h4040_0000, 3'd0), "sub");
    chk("sub_flags", 64'({Sub_Sign_o, Invalid_early_o}), 64'b10);

    send_alone(mk(32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 3'b101), "rm5");
    chk("rm5", 64'({Rounding_mode_o, Rm_illegal_o}), 64'b1011);
    send_alone(mk(32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 3'b100), "rm4");
    chk("rm4", 64'({Rounding_mode_o, Rm_illegal_o}), 64'b1000);

    // Stall: four cycles with the consumer blocked; only two sets fit.
    for (int i = 0; i < 5; i++) st[i] = rnd_set();
    idx = 0;
    for (int k = 0; k < 4; k++) begin
      cycle(1'b1, st[idx], 1'b0);
      if (last_acc) idx++;
    end
    chk("stall_accepted", 64'(idx), 64'd2);
    chk("stall_in_ready", 64'(In_ready_o), 64'(0));
    for (int k = 0; k < 20 && idx < 5; k++) begin
      cycle(1'b1, st[idx], 1'b1);
      if (last_acc) idx++;
    end
    chk("stall_all_sent", 64'(idx), 64'd5);
    for (int k = 0; k < 10 && sb.size() != 0; k++) cycle(1'b0, z, 1'b1);
    chk("stall_drained", 64'(sb.size()), 64'(0));

    // Reset with two sets in flight.
    cycle(1'b1, rnd_set(), 1'b0);
    cycle(1'b1, rnd_set(), 1'b0);
    @(negedge clk);
    rst = 1'b1; In_valid_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    #1;
    chk("midrst_out_valid", 64'(Out_valid_o), 64'(0));
    chk("midrst_in_ready", 64'(In_ready_o), 64'(1));
    chk("midrst_data", 64'({A_Mant_o, B_Mant_o}), 64'(0));
    send_alone(rnd_set(), "postrst");

    for (int k = 0; k < 400; k++)
      cycle($urandom_range(0, 3) != 0, rnd_set(), $urandom_range(0, 3) != 0);
    for (int k = 0; k < 10 && sb.size() != 0; k++) cycle(1'b0, z, 1'b1);
    chk("final_drained", 64'(sb.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
